parser_scheduler: RTL and testbench
===================================

PARSER_SCHEDULER -- requirements
Module: parser_scheduler

Interface
REQ-001 The block SHALL have parameter N_PORTS, default 4, giving the number of packet requesters (2..8).
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  N_PORTS  per-port packet offered.
- req_pkt_flat  in  N_PORTS*12144  per-port 1518-byte frame; port p occupies bits [12144*p +: 12144].
- req_ready  out  N_PORTS  per-port accept, one-hot or zero.
- par_pkt_flat  out  12144  frame muxed to the shared parser.
- par_valid  out  1  parser valid strobe.
- par_features_flat  in  640  parser result, registered one cycle after par_valid.
- feat_valid  out  1  feature vector available downstream.
- feat_data  out  640  captured feature vector.
- feat_port  out  $clog2(N_PORTS)  source port of feat_data.
- feat_ready  in  1  downstream accept.

Function
REQ-003 The FSM SHALL have three states (IDLE, CAPT, OUT) and leave reset in IDLE.
REQ-004 In IDLE with any req_valid set, the block SHALL grant exactly one port p, chosen round-robin starting at last_grant+1 mod N_PORTS.
- Same cycle: req_ready[p]=1, par_valid=1, par_pkt_flat=port p's frame.
- Next state: CAPT.
REQ-005 In IDLE with no req_valid, par_valid, par_pkt_flat and req_ready SHALL all be 0.
REQ-006 last_grant SHALL update only on a granted cycle; after reset it SHALL be N_PORTS-1, so port 0 wins first.
REQ-007 In CAPT the block SHALL register par_features_flat into feat_data and the granted index into feat_port, then go to OUT; req_ready=0 and par_valid=0 throughout.
REQ-008 In OUT, feat_valid SHALL be 1 and feat_data/feat_port SHALL hold stable until feat_ready=1.
- On feat_valid && feat_ready: next state IDLE.
REQ-009 Latency SHALL be 2 cycles from the grant cycle to the first feat_valid cycle.
- Minimum spacing between grants: 3 cycles.
REQ-010 Outside IDLE, req_ready SHALL be all-zero; no port's request is lost.
REQ-011 A requester SHALL hold req_valid and its frame until granted; the bench SHALL flag a withdrawn request.
REQ-012 Simultaneous requests from all ports SHALL be served in strict rotation, so no port waits more than N_PORTS grants.
REQ-013 If feat_ready is already 1 when feat_valid rises, the vector SHALL transfer in that first OUT cycle.

Reset
REQ-014 Reset SHALL force:
- IDLE state and last_grant=N_PORTS-1.
- feat_valid=0, feat_data=0, feat_port=0.
- req_ready=0, par_valid=0.
REQ-015 Reset mid-operation SHALL abandon the in-flight packet; it is not replayed and its requester must re-offer.

Configuration
REQ-016 With PARSER_SCHED_STATS_EN defined, the block SHALL add two outputs:
- stat_pkts[31:0]: counts feat_valid&&feat_ready handshakes.
- stat_stall[31:0]: counts OUT cycles with feat_ready=0.
- Both SHALL saturate at 32'hFFFFFFFF and clear on rst.
REQ-017 Without PARSER_SCHED_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-018 Constants PKT_BYTES=1518, PKT_W=12144, FEAT_W=640 and the FSM state enum SHALL live in the shared package nids_pkg.
REQ-019 Round-robin selection SHALL be one sub-module, rr_arbiter.
- Inputs: request vector, last_grant, enable.
- Outputs: one-hot grant and its index.

Verification
REQ-020 Single request: req_valid=4'b0100 at cycle 0 -> req_ready=4'b0100 and par_valid at 0; feat_valid at 2 with feat_port=2 and feat_data equal to the model parser output.
REQ-021 All ports requesting after reset, feat_ready=1 -> grant order 0,1,2,3,0, one grant every 3 cycles.
REQ-022 Backpressure: feat_ready=0 for 5 cycles -> feat_data stable, no req_ready, stat_stall=5 (macro on).
REQ-023 Reset asserted in CAPT -> next cycle feat_valid=0 and state IDLE; port 0 wins the following grant.
REQ-024 Build without PARSER_SCHED_STATS_EN -> same traces as REQ-020..023 and no stat_* ports.

Source files
------------

// File: rtl/nids_pkg.sv
// Shared constants and types for the NIDS packet path.
package nids_pkg;

    localparam int unsigned PKT_BYTES = 1518;
    localparam int unsigned PKT_W     = PKT_BYTES * 8;
    localparam int unsigned FEAT_W    = 640;

    typedef enum logic [1:0] {
        StIdle,
        StCapt,
        StOut
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from last_grant+1 (mod N_PORTS) and
// returns a one-hot grant plus its binary index. No grant when enable is low.
module rr_arbiter #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned IDX_W   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    input  logic               enable,
    output logic [N_PORTS-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Rotating priority search; the first requester after last_grant wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_PORTS; k++) begin
            cand = IDX_W'((32'(last_grant) + k) % N_PORTS);
            if (enable && !found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parser_scheduler.sv
// Shares one packet parser among N_PORTS requesters. A granted frame is
// presented to the parser, its feature vector is captured the next cycle and
// held on the output until downstream accepts it.
// Optional statistics counters are enabled by defining PARSER_SCHED_STATS_EN.
module parser_scheduler
    import nids_pkg::*;
#(
    parameter int unsigned N_PORTS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_PORTS-1:0]           req_valid,
    input  logic [N_PORTS*PKT_W-1:0]     req_pkt_flat,
    output logic [N_PORTS-1:0]           req_ready,
    output logic [PKT_W-1:0]             par_pkt_flat,
    output logic                         par_valid,
    input  logic [FEAT_W-1:0]            par_features_flat,
    output logic                         feat_valid,
    output logic [FEAT_W-1:0]            feat_data,
    output logic [$clog2(N_PORTS)-1:0]   feat_port,
    input  logic                         feat_ready
`ifdef PARSER_SCHED_STATS_EN
    ,
    output logic [31:0]                  stat_pkts,
    output logic [31:0]                  stat_stall
`endif
);

    localparam int unsigned IDX_W = $clog2(N_PORTS);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] last_grant_q;
    logic [IDX_W-1:0] grant_idx;
    logic [N_PORTS-1:0] grant;
    logic [FEAT_W-1:0] feat_data_q;
    logic [IDX_W-1:0] feat_port_q;
    logic             arb_en;

    // No grant while reset is asserted, so an abandoned cycle never moves last_grant
    assign arb_en = (state_q == StIdle) && !rst;

    rr_arbiter #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .enable     (arb_en),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|grant) state_d = StCapt;
            StCapt:  state_d = StOut;
            StOut:   if (feat_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: grant and parser feed are combinational in the grant cycle
    always_comb begin
        req_ready    = grant;
        par_valid    = |grant;
        par_pkt_flat = '0;
        if (|grant) par_pkt_flat = req_pkt_flat[32'(grant_idx) * PKT_W +: PKT_W];
        feat_valid   = (state_q == StOut);
    end

    // Grant history and feature capture; last_grant doubles as the in-flight port
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= IDX_W'(N_PORTS - 1);
            feat_data_q  <= '0;
            feat_port_q  <= '0;
        end else begin
            if (|grant) last_grant_q <= grant_idx;
            if (state_q == StCapt) begin
                feat_data_q <= par_features_flat;
                feat_port_q <= last_grant_q;
            end
        end
    end

    assign feat_data = feat_data_q;
    assign feat_port = feat_port_q;

`ifdef PARSER_SCHED_STATS_EN
    logic [31:0] stat_pkts_q, stat_stall_q;

    // Saturating handshake and stall counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            if (feat_valid && feat_ready && stat_pkts_q != 32'hFFFF_FFFF)
                stat_pkts_q <= stat_pkts_q + 32'd1;
            if (feat_valid && !feat_ready && stat_stall_q != 32'hFFFF_FFFF)
                stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_pkts  = stat_pkts_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_parser_scheduler.sv
// Bench for parser_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the scheduler.
module tb_parser_scheduler;
    import nids_pkg::*;

    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N*PKT_W-1:0]   req_pkt_flat;
    logic [N-1:0]         req_ready;
    logic [PKT_W-1:0]     par_pkt_flat;
    logic                 par_valid;
    logic [FEAT_W-1:0]    par_features_flat;
    logic                 feat_valid;
    logic [FEAT_W-1:0]    feat_data;
    logic [1:0]           feat_port;
    logic                 feat_ready;
`ifdef PARSER_SCHED_STATS_EN
    logic [31:0]          stat_pkts, stat_stall;
`endif

    always #5 clk = ~clk;

    parser_scheduler #(.N_PORTS(N)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_pkt_flat      (req_pkt_flat),
        .req_ready         (req_ready),
        .par_pkt_flat      (par_pkt_flat),
        .par_valid         (par_valid),
        .par_features_flat (par_features_flat),
        .feat_valid        (feat_valid),
        .feat_data         (feat_data),
        .feat_port         (feat_port),
        .feat_ready        (feat_ready)
`ifdef PARSER_SCHED_STATS_EN
        ,
        .stat_pkts         (stat_pkts),
        .stat_stall        (stat_stall)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Requester side
    logic [PKT_W-1:0] frames [N];
    bit   [N-1:0]     req_active;
    bit               rst_drive, fr_drive;
    int               mode;            // 0 manual, 1 random offers, 2 all ports always offering

    // Model: transaction view of the scheduler
    bit               m_busy;
    int               m_age;           // cycles since grant
    int               m_port;
    int               m_last;
    logic [FEAT_W-1:0] m_feat;
    longint unsigned  m_pkts, m_stall;

    int g_port[$];
    int g_cyc[$];

    function automatic logic [PKT_W-1:0] rand_frame();
        logic [PKT_W-1:0] f;
        for (int i = 0; i < PKT_W; i += 16) f[i +: 16] = 16'($urandom);
        return f;
    endfunction

    function automatic logic [FEAT_W-1:0] rand_feat();
        logic [FEAT_W-1:0] f;
        for (int i = 0; i < FEAT_W; i += 16) f[i +: 16] = 16'($urandom);
        return f;
    endfunction

    // Stand-in parser function
    function automatic logic [FEAT_W-1:0] parse(input logic [PKT_W-1:0] f);
        return f[FEAT_W-1:0] ^ f[2*FEAT_W-1:FEAT_W];
    endfunction

    function automatic logic [31:0] fold_pkt(input logic [PKT_W-1:0] f);
        logic [31:0] r = '0;
        for (int i = 0; i < PKT_W; i += 16) r = {r[30:0], r[31]} ^ 32'(f[i +: 16]);
        return r;
    endfunction

    function automatic logic [31:0] fold_feat(input logic [FEAT_W-1:0] f);
        logic [31:0] r = '0;
        for (int i = 0; i < FEAT_W; i += 16) r = {r[30:0], r[31]} ^ 32'(f[i +: 16]);
        return r;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Registered parser: result appears the cycle after par_valid, noise otherwise
    always @(posedge clk) par_features_flat <= par_valid ? parse(par_pkt_flat) : rand_feat();

    task automatic chk(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic offer(input int p);
        req_active[p] = 1'b1;
        frames[p]     = rand_frame();
    endtask

    // One clock cycle: drive, compare against the model, advance the model
    task automatic step();
        logic [N-1:0] exp_ready;
        int           pick;
        bit           grant_now;
        @(negedge clk);
        rst        = rst_drive;
        feat_ready = fr_drive;
        req_valid  = req_active;
        for (int p = 0; p < N; p++) req_pkt_flat[p*PKT_W +: PKT_W] = frames[p];
        #1;
        pick = -1;
        if (!rst_drive && !m_busy) begin
            for (int k = 1; k <= N; k++) begin
                int p = (m_last + k) % N;
                if (pick < 0 && req_active[p]) pick = p;
            end
        end
        grant_now = (pick >= 0);
        exp_ready = grant_now ? (N'(1) << pick) : '0;
        if (rst_drive) begin
            chk("rst_req_ready", req_ready == '0, 64'(req_ready), 64'(0));
            chk("rst_par_valid", par_valid == 1'b0, 64'(par_valid), 64'(0));
        end else begin
            chk("req_ready", req_ready == exp_ready, 64'(req_ready), 64'(exp_ready));
            chk("par_valid", par_valid == grant_now, 64'(par_valid), 64'(grant_now));
            if (grant_now)
                chk("par_pkt", par_pkt_flat == frames[pick], 64'(fold_pkt(par_pkt_flat)),
                    64'(fold_pkt(frames[pick])));
            else
                chk("par_pkt_zero", par_pkt_flat == '0, 64'(fold_pkt(par_pkt_flat)), 64'(0));
            chk("feat_valid", feat_valid == (m_busy && m_age >= 2), 64'(feat_valid),
                64'(m_busy && m_age >= 2));
            if (m_busy && m_age >= 2) begin
                chk("feat_data", feat_data == m_feat, 64'(fold_feat(feat_data)),
                    64'(fold_feat(m_feat)));
                chk("feat_port", int'(feat_port) == m_port, 64'(feat_port), 64'(m_port));
            end
`ifdef PARSER_SCHED_STATS_EN
            chk("stat_pkts", stat_pkts == 32'(m_pkts), 64'(stat_pkts), m_pkts);
            chk("stat_stall", stat_stall == 32'(m_stall), 64'(stat_stall), m_stall);
`endif
        end
        if (req_ready != '0) begin
            g_port.push_back(idx_of(req_ready));
            g_cyc.push_back(cyc);
        end
        // Advance the model to the next cycle
        if (rst_drive) begin
            m_busy  = 1'b0;
            m_last  = N - 1;
            m_pkts  = 0;
            m_stall = 0;
        end else if (grant_now) begin
            m_busy = 1'b1;
            m_age  = 1;
            m_port = pick;
            m_last = pick;
            m_feat = parse(frames[pick]);
            req_active[pick] = 1'b0;
        end else if (m_busy) begin
            if (m_age >= 2) begin
                if (fr_drive) begin
                    m_busy = 1'b0;
                    m_pkts++;
                end else begin
                    m_stall++;
                end
            end else begin
                m_age++;
            end
        end
        if (mode == 1) begin
            for (int p = 0; p < N; p++)
                if (!req_active[p] && $urandom_range(0, 2) == 0) offer(p);
        end else if (mode == 2) begin
            for (int p = 0; p < N; p++) if (!req_active[p]) offer(p);
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_drive  = 1'b1;
        req_active = '0;
        step();
        rst_drive  = 1'b0;
    endtask

    initial begin
        logic [FEAT_W-1:0] want;
        int exp_order [5];
        rst = 1'b1; feat_ready = 1'b1; req_valid = '0; req_pkt_flat = '0;
        rst_drive = 1'b1; fr_drive = 1'b1; req_active = '0; mode = 0;
        m_busy = 1'b0; m_age = 0; m_port = 0; m_last = N - 1; m_feat = '0;
        m_pkts = 0; m_stall = 0;
        for (int p = 0; p < N; p++) frames[p] = rand_frame();

        // Reset state
        repeat (2) step();
        rst_drive = 1'b0;
        step();
        chk("reset_feat_valid", feat_valid == 1'b0, 64'(feat_valid), 64'(0));
        chk("reset_feat_data", feat_data == '0, 64'(fold_feat(feat_data)), 64'(0));
        chk("reset_feat_port", feat_port == 2'd0, 64'(feat_port), 64'(0));
        chk("reset_req_ready", req_ready == 4'b0000, 64'(req_ready), 64'(0));

        // Single request on port 2
        offer(2);
        want = parse(frames[2]);
        step();
        chk("single_ready", req_ready == 4'b0100, 64'(req_ready), 64'h4);
        chk("single_par_valid", par_valid == 1'b1, 64'(par_valid), 64'(1));
        step();
        chk("single_capt_idle_out", feat_valid == 1'b0, 64'(feat_valid), 64'(0));
        step();
        chk("single_feat_valid", feat_valid == 1'b1, 64'(feat_valid), 64'(1));
        chk("single_feat_port", feat_port == 2'd2, 64'(feat_port), 64'(2));
        chk("single_feat_data", feat_data == want, 64'(fold_feat(feat_data)),
            64'(fold_feat(want)));
        step();

        // All ports requesting: strict rotation, one grant per 3 cycles
        do_reset();
        g_port.delete();
        g_cyc.delete();
        mode = 2;
        for (int p = 0; p < N; p++) offer(p);
        repeat (13) step();
        mode = 0;
        exp_order = '{0, 1, 2, 3, 0};
        chk("rot_count", g_port.size() >= 5, 64'(g_port.size()), 64'(5));
        if (g_port.size() >= 5) begin
            for (int i = 0; i < 5; i++)
                chk("rot_order", g_port[i] == exp_order[i], 64'(g_port[i]), 64'(exp_order[i]));
            for (int i = 1; i < 5; i++)
                chk("rot_spacing", g_cyc[i] - g_cyc[i-1] == 3, 64'(g_cyc[i] - g_cyc[i-1]),
                    64'(3));
        end

        // Backpressure: five stalled OUT cycles, competing request held off
        do_reset();
        fr_drive = 1'b0;
        offer(1);
        step();
        step();
        offer(3);
        repeat (5) begin
            step();
            chk("bp_no_ready", req_ready == 4'b0000, 64'(req_ready), 64'(0));
            chk("bp_feat_port", feat_port == 2'd1, 64'(feat_port), 64'(1));
        end
        fr_drive = 1'b1;
        step();
        step();
        chk("bp_next_grant", req_ready == 4'b1000, 64'(req_ready), 64'h8);
`ifdef PARSER_SCHED_STATS_EN
        chk("bp_stat_stall", stat_stall == 32'd5, 64'(stat_stall), 64'(5));
        chk("bp_stat_pkts", stat_pkts == 32'd1, 64'(stat_pkts), 64'(1));
`endif
        repeat (3) step();

        // Reset while capturing abandons the packet; port 0 wins afterwards
        do_reset();
        offer(2);
        step();
        rst_drive = 1'b1;
        step();
        rst_drive = 1'b0;
        offer(3);
        offer(0);
        step();
        chk("rstcapt_feat_valid", feat_valid == 1'b0, 64'(feat_valid), 64'(0));
        chk("rstcapt_grant", req_ready == 4'b0001, 64'(req_ready), 64'h1);
        repeat (8) step();

        // Randomized traffic with backpressure and occasional reset
        mode = 1;
        repeat (600) begin
            fr_drive  = ($urandom_range(0, 3) != 0);
            rst_drive = ($urandom_range(0, 199) == 0);
            step();
        end
        mode = 0;
        rst_drive = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
